wlm_to_mont: RTL
================

Name: wlm_to_mont

Overview:
- Iterative Montgomery-domain encoder: computes T = A·2^SHIFT mod q for the word-level Montgomery-friendly modulus q = qH·2^(LOGQ-LOGQH) + 1.
- It is the entry-side counterpart of the word-level reduction datapath. It maps operands into the Montgomery domain so that the downstream reduction returns true residues.
- Shift-and-conditional-subtract engine: one modular doubling per cycle.
- Valid/ready handshakes on both sides.

Parameters:
- LOGQ, 60, modulus bit width; also the width of A and T.
- LOGQH, 17, width of qH (high part of q).
- SHIFT, 60, Montgomery exponent; R = 2^SHIFT. Must be ≥1.
- CW, $clog2(SHIFT+1), iteration counter width (derived, localparam).

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-low reset.
- qH, input, LOGQH, modulus high part; sampled on accept. qH[LOGQH-1] must be 1, otherwise the result is undefined.
- in_valid, input, 1, A/qH valid.
- in_ready, output, 1, encoder idle and able to accept.
- A, input, LOGQ, operand; any value in 0..2^LOGQ-1.
- out_valid, output, 1, T valid.
- out_ready, input, 1, consumer accepts T.
- T, output, LOGQ, A·2^SHIFT mod q, fully reduced (0 ≤ T < q).

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, counter=0, T register=0, out_valid=0, in_ready=1 after the edge.
  - Reset overrides everything, including mid-operation: any in-flight result is discarded and no out_valid is produced for it.
- Internal registers:
  - q_r (LOGQ bits), formed as {qH, (LOGQ-LOGQH-1) zeros, 1'b1} at accept.
  - x (LOGQ bits), the running residue.
  - cnt (CW bits).
- FSM states IDLE, PRE, SHIFT, DONE:
  - IDLE: in_ready=1. When in_valid=1, accept (edge E0): x←A, q_r←q, state←PRE.
  - PRE: one cycle. If x ≥ q_r then x←x−q_r, else hold. Valid because A < 2^LOGQ < 2q when qH MSB=1. Then cnt←SHIFT, state←SHIFT.
  - SHIFT: each cycle compute d = {x,1'b0} in LOGQ+1 bits. If d ≥ q_r then x←d−q_r, else x←d[LOGQ-1:0]. Decrement cnt. When cnt reaches 1 on this update, state←DONE and out_valid←1.
  - DONE: out_valid=1 and T=x, held stable until out_ready=1. On the handshake edge: out_valid←0, state←IDLE.
- in_ready is low in PRE, SHIFT and DONE; no accept in the same cycle as the output handshake.
- Latency: accept at edge E0, out_valid high after edge E0+SHIFT+1. With zero output backpressure, minimum initiation interval is SHIFT+3 cycles.
- Arithmetic:
  - Comparator/subtractor is LOGQ+1 bits wide.
  - Invariant: x < q_r after PRE and after every SHIFT step.
  - No overflow is possible since d < 2q < 2^(LOGQ+1).
- Boundary behaviour:
  - A=0 gives T=0.
  - A=q−1 gives q−2^SHIFT mod q.
  - A ≥ q is handled by PRE.
  - A changing while in_ready=0 is ignored. qH is only sampled at accept; later changes do not affect the result.
  - out_ready asserted while out_valid=0 has no effect.
  - in_valid held continuously produces back-to-back operations, each accepted in IDLE.

Test Plan:
- Config LOGQ=8, LOGQH=3, SHIFT=8, qH=3'b101 (q=161). A=1 → T=95; out_valid rises exactly 9 cycles after the accept edge.
- Same config, A=160 → T=66. A=0 → T=0. A=200 (≥q, exercises PRE) → T=2.
- Backpressure: A=1 with out_ready=0 for 5 cycles after out_valid → T=95 held stable, in_ready stays 0, and exactly one handshake occurs on out_ready=1.
- Reset mid-op: rst=0 for one edge during SHIFT (cnt=4) → next cycle in_ready=1, out_valid=0, T=0. Next accept A=1 → T=95 normally.
- Randomized self-check at defaults (LOGQ=60, LOGQH=17, SHIFT=60), random qH with MSB=1:
  - ≥1000 operands against a reference model of (A·2^60) mod q.
  - Random in_valid/out_ready gaps.
  - qH and A toggled during busy cycles must not alter results.

Source files
------------

// File: rtl/wlm_to_mont.sv
`default_nettype none
// ============================================================================
//  Module      : wlm_to_mont
//  Description : Iterative Montgomery-domain encoder. Computes
//                T = A * 2^SHIFT mod q for the word-level Montgomery-friendly
//                modulus q = qH * 2^(LOGQ-LOGQH) + 1, one modular doubling per
//                cycle, with valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module wlm_to_mont #(
   parameter int LOGQ  = 60,
   parameter int LOGQH = 17,
   parameter int SHIFT = 60
) (
   input  logic             clk,
   input  logic             rst,        // synchronous, active low
   input  logic [LOGQH-1:0] qH,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LOGQ-1:0]  A,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOGQ-1:0]  T
);

   localparam int CW = $clog2(SHIFT + 1);

   localparam logic [CW-1:0]   c_CNT_INIT = CW'(SHIFT);
   localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);
   localparam logic [LOGQ-1:0] c_Q_LSB    = LOGQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRE   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [LOGQ-1:0]  r_q;
   logic [LOGQ-1:0]  r_x;
   logic [CW-1:0]    r_cnt;

   logic [LOGQ-1:0]  w_q_new;
   logic [LOGQ:0]    w_opnd;
   logic [LOGQ:0]    w_diff;
   logic             w_ge;
   logic [LOGQ-1:0]  w_x_red;
   logic             w_accept;
   logic             w_last;

   // Modulus as seen by the datapath: qH in the top bits, a single 1 in the LSB.
   always_comb begin
      w_q_new = ({{(LOGQ-LOGQH){1'b0}}, qH} << (LOGQ - LOGQH)) | c_Q_LSB;
   end

   // One conditional-subtract stage shared by PRE (x) and SHIFT (2x);
   // LOGQ+1 bits suffices because the operand is always below 2q.
   always_comb begin
      w_opnd  = (r_state == S_SHIFT) ? {r_x, 1'b0} : {1'b0, r_x};
      w_diff  = w_opnd - {1'b0, r_q};
      w_ge    = (w_opnd >= {1'b0, r_q});
      w_x_red = w_ge ? w_diff[LOGQ-1:0] : w_opnd[LOGQ-1:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs decoded from the current state.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_accept     = 1'b0;
      w_last       = (r_cnt == c_CNT_ONE);
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_PRE;
            end
         end
         S_PRE: begin
            w_state_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath registers: capture on accept, reduce in PRE, double in SHIFT.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_x   <= '0;
         r_q   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x <= A;
                  r_q <= w_q_new;
               end
            end
            S_PRE: begin
               r_x   <= w_x_red;
               r_cnt <= c_CNT_INIT;
            end
            S_SHIFT: begin
               r_x   <= w_x_red;
               r_cnt <= r_cnt - c_CNT_ONE;
            end
            default: begin
               r_x <= r_x;
            end
         endcase
      end
   end

   // The running residue is the result once the engine reaches DONE.
   always_comb begin
      T = r_x;
   end

endmodule
`default_nettype wire
